// File: rtl/gpio_in_filter.sv
//------------------------------------------------------------------------------
// Module   : gpio_in_filter
// Desc     : Per-pin pad synchroniser and debounce filter feeding gpio_ext_porta.
//            `GPIO_FLT_SYNC3_EN selects a 3-flop synchroniser (2-flop default).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpio_in_filter #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [DW-1:0]    pad_in,
  input  logic [DW-1:0]    flt_en,
  input  logic [CNT_W-1:0] flt_len,
  output logic [DW-1:0]    gpio_ext_porta,
  output logic [DW-1:0]    chg_pulse
);

  logic [DW-1:0] r_sync1;
  logic [DW-1:0] r_sync2;
  logic [DW-1:0] w_sync;
  logic [DW-1:0] r_flt;
  logic [DW-1:0] r_chg;
  logic [DW-1:0] w_flt_next;

`ifdef GPIO_FLT_SYNC3_EN
  logic [DW-1:0] r_sync3;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= pad_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_sync = r_sync3;
`else
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync = r_sync2;
`endif

  // Each pin owns its counter; only flt_len is shared. Since c only advances
  // while c < flt_len, it can never exceed the counter range and never wraps.
  for (genvar i = 0; i < DW; i++) begin : g_pin
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_f_next;

    always_comb begin
      w_f_next   = r_flt[i];
      w_cnt_next = '0;
      if (!flt_en[i]) begin
        w_f_next = w_sync[i];
      end else if (w_sync[i] != r_flt[i]) begin
        if (r_cnt >= flt_len) begin
          w_f_next = w_sync[i];
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end

    assign w_flt_next[i] = w_f_next;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_flt <= '0;
      r_chg <= '0;
    end else begin
      r_flt <= w_flt_next;
      r_chg <= w_flt_next ^ r_flt;
    end
  end

  assign gpio_ext_porta = r_flt;
  assign chg_pulse      = r_chg;

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_filter.sv
//------------------------------------------------------------------------------
// Module   : tb_gpio_in_filter
// Desc     : Directed vector table plus multi-cycle sequences for gpio_in_filter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gpio_in_filter;

`ifdef GPIO_FLT_SYNC3_EN
  localparam int c_x = 1;
`else
  localparam int c_x = 0;
`endif

  logic        pclk;
  logic        presetn;
  logic [31:0] pad_in;
  logic [31:0] flt_en;
  logic [7:0]  flt_len;
  logic [31:0] gpio_ext_porta;
  logic [31:0] chg_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_in_filter #(.DW(32), .CNT_W(8)) dut (
    .pclk           (pclk),
    .presetn        (presetn),
    .pad_in         (pad_in),
    .flt_en         (flt_en),
    .flt_len        (flt_len),
    .gpio_ext_porta (gpio_ext_porta),
    .chg_pulse      (chg_pulse)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] pad;
    logic [31:0] en;
    logic [7:0]  len;
    int          edges;
    logic [31:0] exp_porta;
    logic [31:0] exp_chg;
  } vec_t;

  vec_t vecs[8];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    int pulses;
    logic seen;

    // Bypass latency is 3 edges; filtered vectors wait 3+N edges.
    vecs[0] = '{32'h0000_0000, 32'h0, 8'd0, 3, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[1] = '{32'hA5A5_0F0F, 32'h0, 8'd0, 3, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    vecs[2] = '{32'h5A5A_F0F0, 32'h0, 8'd0, 3, 32'h5A5A_F0F0, 32'hFFFF_FFFF};
    vecs[3] = '{32'h5A5A_F0F0, 32'h0, 8'd0, 3, 32'h5A5A_F0F0, 32'h0000_0000};
    vecs[4] = '{32'h8000_0001, 32'h0, 8'd0, 3, 32'h8000_0001, 32'hDA5A_F0F1};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 8'd2, 5, 32'h0000_0000, 32'h8000_0001};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 8'd2, 3, 32'hFFFF_0000, 32'hFFFF_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 8'd2, 2, 32'hFFFF_FFFF, 32'h0000_FFFF};

    // Reset with pads high: outputs stay zero, then a single 0->1 change.
    presetn = 1'b0;
    pad_in  = 32'hFFFF_FFFF;
    flt_en  = 32'h0;
    flt_len = 8'd0;
    step(3);
    check("reset_porta", gpio_ext_porta, 32'h0);
    check("reset_chg", chg_pulse, 32'h0);
    presetn = 1'b1;
    step(2 + c_x);
    check("rel_porta_pre", gpio_ext_porta, 32'h0);
    step(1);
    check("rel_porta", gpio_ext_porta, 32'hFFFF_FFFF);
    check("rel_chg", chg_pulse, 32'hFFFF_FFFF);
    step(1);
    check("rel_chg_clear", chg_pulse, 32'h0);

    for (int i = 0; i < 8; i++) begin
      pad_in  = vecs[i].pad;
      flt_en  = vecs[i].en;
      flt_len = vecs[i].len;
      step(vecs[i].edges + c_x);
      check($sformatf("vec%0d_porta", i), gpio_ext_porta, vecs[i].exp_porta);
      check($sformatf("vec%0d_chg", i), chg_pulse, vecs[i].exp_chg);
    end

    // Clean baseline: all pads low, bypass.
    pad_in = 32'h0;
    flt_en = 32'h0;
    step(4 + c_x);
    check("base_porta", gpio_ext_porta, 32'h0);

    // Pin 0, N=4: rises on edge 7 with exactly one pulse.
    flt_en  = 32'h1;
    flt_len = 8'd4;
    step(2);
    pad_in[0] = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 10 + c_x; e++) begin
      step(1);
      if (chg_pulse[0]) pulses++;
      if (e == 6 + c_x) check("p0_e6", {31'h0, gpio_ext_porta[0]}, 32'h0);
      if (e == 7 + c_x) begin
        check("p0_e7", {31'h0, gpio_ext_porta[0]}, 32'h1);
        check("p0_e7_chg", {31'h0, chg_pulse[0]}, 32'h1);
      end
    end
    check("p0_pulses", pulses, 32'd1);

    // Pin 1, N=4: a 4-cycle high glitch is rejected.
    flt_en    = 32'h3;
    pad_in[1] = 1'b1;
    seen      = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      if (e == 4) pad_in[1] = 1'b0;
      if (gpio_ext_porta[1] || chg_pulse[1]) seen = 1'b1;
    end
    check("p1_glitch", {31'h0, seen}, 32'h0);

    // Pin 3: count to c=6 under N=10, then N drops to 3 -> immediate accept.
    flt_en    = 32'hB;
    flt_len   = 8'd10;
    step(1);
    pad_in[3] = 1'b1;
    step(8 + c_x);
    check("p3_c6", {31'h0, gpio_ext_porta[3]}, 32'h0);
    flt_len = 8'd3;
    step(1);
    check("p3_accept", {31'h0, gpio_ext_porta[3]}, 32'h1);
    check("p3_chg", {31'h0, chg_pulse[3]}, 32'h1);
    // Counter restarted: the falling edge needs the full 3+3 edges.
    pad_in[3] = 1'b0;
    step(5 + c_x);
    check("p3_fall_e5", {31'h0, gpio_ext_porta[3]}, 32'h1);
    step(1);
    check("p3_fall_e6", {31'h0, gpio_ext_porta[3]}, 32'h0);

    // Pin 2: filter disabled mid-count accepts the pending level next edge.
    flt_len   = 8'd10;
    flt_en    = 32'hF;
    step(1);
    pad_in[2] = 1'b1;
    step(4 + c_x);
    check("p2_c2", {31'h0, gpio_ext_porta[2]}, 32'h0);
    flt_en[2] = 1'b0;
    step(1);
    check("p2_bypass", {31'h0, gpio_ext_porta[2]}, 32'h1);
    check("p2_chg", {31'h0, chg_pulse[2]}, 32'h1);

    // Pin 4: reset at c=5 under N=8 loses the change; full 3+8 afterwards.
    flt_len   = 8'd8;
    flt_en    = 32'h1B;
    step(1);
    pad_in[4] = 1'b1;
    step(7 + c_x);
    check("p4_pre_rst", {31'h0, gpio_ext_porta[4]}, 32'h0);
    presetn = 1'b0;
    #1;
    check("arst_porta", gpio_ext_porta, 32'h0);
    check("arst_chg", chg_pulse, 32'h0);
    step(1);
    presetn = 1'b1;
    step(10 + c_x);
    check("p4_e10", {31'h0, gpio_ext_porta[4]}, 32'h0);
    step(1);
    check("p4_e11", {31'h0, gpio_ext_porta[4]}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
